boot_loader_ctrl: RTL and testbench
===================================

// Module: boot_loader_ctrl
// PURPOSE
//  Boot controller upstream of cpu_top. Holds the CPU in reset while it receives a program image
//  as a byte stream from the UART receiver. Packs the bytes into 32-bit words and writes them
//  into instruction memory. Checks the image checksum, then releases the CPU reset after a hold delay.
// PARAMETERS
//  ADDR_W    10       imem word-address width; capacity 2**ADDR_W words
//  MAGIC     8'hB0    frame start byte
//  TIMEOUT   100000   max idle cycles between bytes inside a frame (>=2)
//  RST_HOLD  16       cycles cpu_rstn_o stays low after a good checksum (>=1)
// PORTS
//  clk_i         in   1       system clock
//  rst_i         in   1       synchronous, active-high reset
//  rx_data_i     in   8       byte from UART receiver
//  rx_valid_i    in   1       rx_data_i valid
//  rx_ready_o    out  1       byte accepted when rx_valid_i & rx_ready_o
//  imem_we_o     out  1       one-cycle instruction-memory write strobe
//  imem_addr_o   out  ADDR_W  word address
//  imem_wdata_o  out  32      write data
//  cpu_rstn_o    out  1       active-low reset into cpu_top rst_i
//  boot_done_o   out  1       high once CPU released
//  boot_err_o    out  1       sticky: last frame failed (csum/length/timeout)
// BEHAVIOUR
//  Reset: state=IDLE; rx_ready_o=1, imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, cpu_rstn_o=0,
//   boot_done_o=0, boot_err_o=0; byte, word, timeout and hold counters cleared. rst_i mid-frame aborts the frame.
//  Frame: MAGIC, LEN_LO, LEN_HI (N = word count, little-endian), 4*N payload bytes, CSUM.
//   CSUM = XOR of all payload bytes. Each word is little-endian: the first byte goes to bits [7:0].
//  FSM (a transition fires on an accepted byte unless stated):
//   IDLE:    MAGIC -> LEN_LO, clear checksum and word counter; any other byte is dropped.
//   LEN_LO -> LEN_HI.
//   LEN_HI:  N > 2**ADDR_W -> ERR; N == 0 -> CSUM; else -> DATA.
//   DATA:    4th byte of a word -> next cycle imem_we_o=1 with addr=word index, data=packed word.
//            Address increments per word from 0. After word N-1 -> CSUM.
//   CSUM:    byte == running XOR -> HOLD; else -> ERR.
//   HOLD:    rx_ready_o=0; count RST_HOLD cycles -> RUN.
//   RUN:     cpu_rstn_o=1, boot_done_o=1, rx_ready_o=0. Terminal until rst_i.
//   ERR:     boot_err_o=1, cpu_rstn_o=0; MAGIC -> LEN_LO. boot_err_o clears on entering HOLD.
//  Timeout: in LEN_LO/LEN_HI/DATA/CSUM, the counter resets on each accepted byte.
//   TIMEOUT consecutive cycles with no accepted byte -> ERR.
//  rx_ready_o=1 in IDLE, LEN_LO, LEN_HI, DATA, CSUM and ERR; accept = valid & ready, one byte per cycle.
//  Back-to-back bytes every cycle are supported. The write strobe overlaps accept of the next word's first byte.
//  imem_we_o is high exactly one cycle per word, never outside DATA→(DATA|CSUM).
//  N == 2**ADDR_W is legal; the last word goes to address 2**ADDR_W-1 and the address never wraps.
//  Checksum mismatch: words already written stay in imem; the CPU is not released.
// STRUCTURE
//  Package boot_pkg: state enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, HOLD, RUN, ERR), default MAGIC.
//  Sub-module byte_packer (4-byte shift + 2-bit count, emits word_valid) is instantiated once.
//  All other logic (FSM, counters, checksum) lives in this module; all outputs are registered.
// TESTING
//  1. Frame B0 02 00 | 13 00 00 00 | 93 00 10 00 | csum=0x90, 1 byte/cycle
//     -> writes (0,0x00000013), (1,0x00100093); cpu_rstn_o rises RST_HOLD cycles after CSUM; boot_done_o=1.
//  2. Same frame with csum=0x91 -> ERR, boot_err_o=1, cpu_rstn_o stays 0.
//     Then resend a correct frame -> RUN, boot_err_o=0.
//  3. N=0: B0 00 00 00 -> no imem_we_o pulse; HOLD then RUN.
//  4. ADDR_W=2, N=5 (LEN 05 00) -> ERR right after LEN_HI; no write issued.
//  5. TIMEOUT=50: stall 50 cycles after 2 payload bytes -> ERR; later bytes are dropped until MAGIC.
//  6. rst_i pulsed mid-DATA -> next cycle all outputs at reset values; new frame boots normally.
//     Also check that in RUN rx_ready_o=0 and input bytes are ignored.

Source files
------------

// File: rtl/boot_loader_ctrl_pkg.sv
// Shared types and constants for the boot loader controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package boot_pkg;

   // Controller states, in the order a good frame walks through them.
   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CSUM,
      HOLD,
      RUN,
      ERR
   } state_t;

   // Default frame start byte.
   localparam logic [7:0] BOOT_MAGIC = 8'hB0;

endpackage

// File: rtl/boot_loader_ctrl_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; the first byte of a word lands in [7:0].
// Latency: word_vld/word_dat are combinational on the cycle the 4th byte arrives.
// Backpressure: none; the packer takes a byte whenever byte_vld is high.
// Ports: clk, rst (sync, active-high), clear (restart at byte 0 of a word),
//        byte_vld/byte_dat (incoming byte), word_vld/word_dat (completed word).
module byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_vld,
   input  logic [7:0]  byte_dat,
   output logic        word_vld,
   output logic [31:0] word_dat
);

   logic [23:0] shift;   // previous three bytes, oldest in [7:0]
   logic [1:0]  cnt;     // bytes already held for the current word

   always_ff @(posedge clk) begin
      if (rst) begin
         shift <= '0;
         cnt   <= '0;
      end else if (clear) begin
         cnt   <= '0;
      end else if (byte_vld) begin
         shift <= {byte_dat, shift[23:8]};
         cnt   <= cnt + 2'd1;   // wraps to 0 after the 4th byte
      end
   end

   // The 4th byte completes the word in the same cycle so the owner can register the write.
   assign word_vld = byte_vld && !clear && (cnt == 2'd3);
   assign word_dat = {byte_dat, shift};

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot controller: receives a framed program image byte-by-byte, writes it to imem, checks the XOR
//   checksum and releases the CPU reset RST_HOLD cycles after a good checksum.
// Latency: imem write one cycle after a word's 4th byte; cpu_rstn_o rises RST_HOLD cycles after CSUM.
// Backpressure: rx_ready_o high in every receiving state, low in HOLD and RUN.
// Ports: clk_i, rst_i (sync, active-high); rx_data_i/rx_valid_i/rx_ready_o byte input;
//        imem_we_o/imem_addr_o/imem_wdata_o word write port; cpu_rstn_o, boot_done_o, boot_err_o status.
module boot_loader_ctrl
   import boot_pkg::*;
#(
   parameter int         ADDR_W   = 10,
   parameter logic [7:0] MAGIC    = BOOT_MAGIC,
   parameter int         TIMEOUT  = 100000,
   parameter int         RST_HOLD = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   output logic              rx_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              cpu_rstn_o,
   output logic              boot_done_o,
   output logic              boot_err_o
);

   localparam int CNT_W  = ADDR_W + 1;              // counts up to 2**ADDR_W words
   localparam int TO_W   = $clog2(TIMEOUT + 1);
   localparam int HOLD_W = $clog2(RST_HOLD + 1);
   localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

   state_t            state;
   logic [7:0]        len_lo;
   logic [CNT_W-1:0]  word_cnt;
   logic [CNT_W-1:0]  word_total;
   logic [7:0]        csum;
   logic [TO_W-1:0]   idle_cnt;
   logic [HOLD_W-1:0] hold_cnt;

   logic        accept;
   logic        is_magic;
   logic        in_frame;
   logic        timed_out;
   logic        start_frame;
   logic [16:0] len_val;
   logic        pk_word_vld;
   logic [31:0] pk_word_dat;

   assign accept      = rx_valid_i && rx_ready_o;
   assign is_magic    = (rx_data_i == MAGIC);
   assign in_frame    = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CSUM);
   assign timed_out   = in_frame && !accept && (idle_cnt == TO_W'(TIMEOUT - 1));
   assign start_frame = accept && is_magic && ((state == IDLE) || (state == ERR));
   assign len_val     = {1'b0, rx_data_i, len_lo};

   byte_packer u_packer (
      .clk      (clk_i),
      .rst      (rst_i),
      .clear    (start_frame),
      .byte_vld (accept && (state == DATA)),
      .byte_dat (rx_data_i),
      .word_vld (pk_word_vld),
      .word_dat (pk_word_dat)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         len_lo       <= '0;
         word_cnt     <= '0;
         word_total   <= '0;
         csum         <= '0;
         idle_cnt     <= '0;
         hold_cnt     <= '0;
         rx_ready_o   <= 1'b1;
         imem_we_o    <= 1'b0;
         imem_addr_o  <= '0;
         imem_wdata_o <= '0;
         cpu_rstn_o   <= 1'b0;
         boot_done_o  <= 1'b0;
         boot_err_o   <= 1'b0;
      end else begin
         imem_we_o <= 1'b0;

         // Inter-byte idle counter only runs while a frame is open.
         if (accept || !in_frame) idle_cnt <= '0;
         else                     idle_cnt <= idle_cnt + TO_W'(1);

         if (timed_out) begin
            state      <= ERR;
            boot_err_o <= 1'b1;
         end else begin
            case (state)
               IDLE, ERR: begin
                  if (start_frame) begin
                     state    <= LEN_LO;
                     csum     <= '0;
                     word_cnt <= '0;
                  end
               end
               LEN_LO: begin
                  if (accept) begin
                     len_lo <= rx_data_i;
                     state  <= LEN_HI;
                  end
               end
               LEN_HI: begin
                  if (accept) begin
                     word_total <= len_val[CNT_W-1:0];
                     if (len_val > MAX_WORDS) begin
                        state      <= ERR;
                        boot_err_o <= 1'b1;
                     end else if (len_val == 17'd0) begin
                        state <= CSUM;
                     end else begin
                        state <= DATA;
                     end
                  end
               end
               DATA: begin
                  if (accept) begin
                     csum <= csum ^ rx_data_i;
                     if (pk_word_vld) begin
                        imem_we_o    <= 1'b1;
                        imem_addr_o  <= word_cnt[ADDR_W-1:0];
                        imem_wdata_o <= pk_word_dat;
                        word_cnt     <= word_cnt + CNT_W'(1);
                        if (word_cnt == word_total - CNT_W'(1)) state <= CSUM;
                     end
                  end
               end
               CSUM: begin
                  if (accept) begin
                     if (rx_data_i == csum) begin
                        state      <= HOLD;
                        rx_ready_o <= 1'b0;
                        boot_err_o <= 1'b0;
                        hold_cnt   <= '0;
                     end else begin
                        state      <= ERR;
                        boot_err_o <= 1'b1;
                     end
                  end
               end
               HOLD: begin
                  if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
                     state       <= RUN;
                     cpu_rstn_o  <= 1'b1;
                     boot_done_o <= 1'b1;
                  end else begin
                     hold_cnt <= hold_cnt + HOLD_W'(1);
                  end
               end
               RUN: begin
                  // Terminal until rst_i; the CPU owns the system now.
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl (ADDR_W=2, TIMEOUT=50, RST_HOLD=16).
// Latency: n/a.
// Backpressure: n/a.
module tb_boot_loader_ctrl;

   localparam int AW = 2;
   localparam int TO = 50;
   localparam int RH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          rx_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_rstn;
   logic          boot_done;
   logic          boot_err;

   int nvec = 0;
   int nerr = 0;

   int          wr_addr[$];
   logic [31:0] wr_data[$];
   logic [7:0]  frame_q[$];
   int          exp_addr[$];
   logic [31:0] exp_data[$];
   bit          exp_ok;

   boot_loader_ctrl #(.ADDR_W(AW), .MAGIC(8'hB0), .TIMEOUT(TO), .RST_HOLD(RH)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .rx_data_i    (rx_data),
      .rx_valid_i   (rx_valid),
      .rx_ready_o   (rx_ready),
      .imem_we_o    (imem_we),
      .imem_addr_o  (imem_addr),
      .imem_wdata_o (imem_wdata),
      .cpu_rstn_o   (cpu_rstn),
      .boot_done_o  (boot_done),
      .boot_err_o   (boot_err)
   );

   always #5 clk = ~clk;

   // Write monitor: every strobe seen mid-cycle is one imem write.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_addr.push_back(int'(imem_addr));
         wr_data.push_back(imem_wdata);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      idle(1);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input int maxgap);
      for (int i = 0; i < frame_q.size(); i++) begin
         if (i > 0 && maxgap > 0) idle($urandom_range(maxgap, 0));
         send_byte(frame_q[i]);
      end
   endtask

   // Reference model: frame bytes and the imem writes/outcome they must produce.
   task automatic build_frame(input int n, input bit corrupt);
      logic [7:0] pay[$];
      logic [7:0] x;
      frame_q.delete();
      exp_addr.delete();
      exp_data.delete();
      frame_q.push_back(8'hB0);
      frame_q.push_back(8'(n));
      frame_q.push_back(8'(n >> 8));
      exp_ok = 1'b0;
      if (n <= (1 << AW)) begin
         x = 8'h00;
         for (int i = 0; i < 4 * n; i++) begin
            pay.push_back(8'($urandom_range(255, 0)));
            x = x ^ pay[i];
            frame_q.push_back(pay[i]);
         end
         for (int w = 0; w < n; w++) begin
            exp_addr.push_back(w);
            exp_data.push_back({pay[4*w+3], pay[4*w+2], pay[4*w+1], pay[4*w]});
         end
         if (corrupt) x = x ^ 8'($urandom_range(255, 1));
         frame_q.push_back(x);
         exp_ok = !corrupt;
      end
   endtask

   task automatic load_basic_frame();
      frame_q = '{8'hB0, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
   endtask

   task automatic test_reset();
      logic [38:0] got;
      rx_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      got = {rx_ready, imem_we, 2'(imem_addr), imem_wdata, cpu_rstn, boot_done, boot_err};
      nvec++;
      if (got !== {1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0}) begin
         nerr++;
         $display("FAIL reset_state got=%h want=%h", got, {1'b1, 1'b0, 2'b00, 32'h0, 3'b000});
      end
      idle(1);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      do_reset();
      load_basic_frame();
      send_frame(0);
      @(negedge clk);
      nvec++;
      if ({rx_ready, cpu_rstn, boot_err} !== 3'b000) begin
         nerr++;
         $display("FAIL basic_hold got=%b want=000", {rx_ready, cpu_rstn, boot_err});
      end
      nvec++;
      if (wr_addr.size() != 2) begin
         nerr++;
         $display("FAIL basic_wr_count got=%0d want=2", wr_addr.size());
      end else begin
         nvec++;
         if (wr_addr[0] != 0 || wr_data[0] !== 32'h00000013) begin
            nerr++;
            $display("FAIL basic_wr0 got=(%0d,%h) want=(0,00000013)", wr_addr[0], wr_data[0]);
         end
         nvec++;
         if (wr_addr[1] != 1 || wr_data[1] !== 32'h00100093) begin
            nerr++;
            $display("FAIL basic_wr1 got=(%0d,%h) want=(1,00100093)", wr_addr[1], wr_data[1]);
         end
      end
      idle(RH - 1);
      @(negedge clk);
      nvec++;
      if (cpu_rstn !== 1'b0) begin
         nerr++;
         $display("FAIL basic_rstn_early got=%b want=0", cpu_rstn);
      end
      idle(1);
      @(negedge clk);
      nvec++;
      if ({cpu_rstn, boot_done, boot_err, rx_ready} !== 4'b1100) begin
         nerr++;
         $display("FAIL basic_run got=%b want=1100", {cpu_rstn, boot_done, boot_err, rx_ready});
      end
   endtask

   task automatic test_bad_csum();
      do_reset();
      load_basic_frame();
      frame_q[11] = 8'h91;
      send_frame(0);
      @(negedge clk);
      nvec++;
      if ({boot_err, cpu_rstn, boot_done, rx_ready} !== 4'b1001 || wr_addr.size() != 2) begin
         nerr++;
         $display("FAIL badcsum_err got=%b writes=%0d want=1001 writes=2",
                  {boot_err, cpu_rstn, boot_done, rx_ready}, wr_addr.size());
      end
      wr_addr.delete();
      wr_data.delete();
      load_basic_frame();
      send_frame(1);
      @(negedge clk);
      nvec++;
      if (boot_err !== 1'b0) begin
         nerr++;
         $display("FAIL badcsum_err_clear got=%b want=0", boot_err);
      end
      idle(RH);
      @(negedge clk);
      nvec++;
      if ({cpu_rstn, boot_done, boot_err} !== 3'b110 || wr_addr.size() != 2) begin
         nerr++;
         $display("FAIL badcsum_recover got=%b writes=%0d want=110 writes=2",
                  {cpu_rstn, boot_done, boot_err}, wr_addr.size());
      end
   endtask

   task automatic test_zero_len();
      do_reset();
      frame_q = '{8'hB0, 8'h00, 8'h00, 8'h00};
      send_frame(0);
      @(negedge clk);
      nvec++;
      if (rx_ready !== 1'b0 || cpu_rstn !== 1'b0) begin
         nerr++;
         $display("FAIL zero_hold got=%b want=00", {rx_ready, cpu_rstn});
      end
      idle(RH);
      @(negedge clk);
      nvec++;
      if ({cpu_rstn, boot_done} !== 2'b11 || wr_addr.size() != 0) begin
         nerr++;
         $display("FAIL zero_run got=%b writes=%0d want=11 writes=0", {cpu_rstn, boot_done}, wr_addr.size());
      end
   endtask

   task automatic test_oversize();
      do_reset();
      frame_q = '{8'hB0, 8'h05, 8'h00};
      send_frame(0);
      @(negedge clk);
      nvec++;
      if ({boot_err, rx_ready} !== 2'b11) begin
         nerr++;
         $display("FAIL oversize_err got=%b want=11", {boot_err, rx_ready});
      end
      frame_q = '{8'h13, 8'h00, 8'h00, 8'h00};
      send_frame(0);
      @(negedge clk);
      nvec++;
      if (wr_addr.size() != 0 || boot_err !== 1'b1) begin
         nerr++;
         $display("FAIL oversize_nowrite writes=%0d err=%b want writes=0 err=1", wr_addr.size(), boot_err);
      end
   endtask

   task automatic test_full_capacity();
      do_reset();
      build_frame(1 << AW, 1'b0);
      send_frame(0);
      @(negedge clk);
      nvec++;
      if (wr_addr.size() != 4 || wr_addr[3] != 3 || wr_data[3] !== exp_data[3]) begin
         nerr++;
         $display("FAIL full_last_word writes=%0d want=4 (addr 3 data %h)", wr_addr.size(), exp_data[3]);
      end
      idle(RH);
      @(negedge clk);
      nvec++;
      if (boot_done !== 1'b1) begin
         nerr++;
         $display("FAIL full_done got=%b want=1", boot_done);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      frame_q = '{8'hB0, 8'h02, 8'h00, 8'hAA, 8'hBB};
      send_frame(0);
      idle(TO - 1);
      @(negedge clk);
      nvec++;
      if (boot_err !== 1'b0) begin
         nerr++;
         $display("FAIL timeout_early got=%b want=0", boot_err);
      end
      idle(1);
      @(negedge clk);
      nvec++;
      if (boot_err !== 1'b1) begin
         nerr++;
         $display("FAIL timeout_err got=%b want=1", boot_err);
      end
      frame_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      send_frame(0);
      @(negedge clk);
      nvec++;
      if (wr_addr.size() != 0 || boot_err !== 1'b1) begin
         nerr++;
         $display("FAIL timeout_drop writes=%0d err=%b want writes=0 err=1", wr_addr.size(), boot_err);
      end
      load_basic_frame();
      send_frame(0);
      idle(RH);
      @(negedge clk);
      nvec++;
      if ({boot_done, boot_err} !== 2'b10 || wr_addr.size() != 2) begin
         nerr++;
         $display("FAIL timeout_recover got=%b writes=%0d want=10 writes=2", {boot_done, boot_err}, wr_addr.size());
      end
   endtask

   task automatic test_reset_mid_and_run();
      logic [38:0] got;
      do_reset();
      frame_q = '{8'hB0, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
      send_frame(0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      got = {rx_ready, imem_we, 2'(imem_addr), imem_wdata, cpu_rstn, boot_done, boot_err};
      nvec++;
      if (got !== {1'b1, 1'b0, 2'b00, 32'h0, 3'b000}) begin
         nerr++;
         $display("FAIL midreset_state got=%h want=%h", got, {1'b1, 1'b0, 2'b00, 32'h0, 3'b000});
      end
      idle(1);
      rst = 1'b0;
      wr_addr.delete();
      wr_data.delete();
      load_basic_frame();
      send_frame(2);
      idle(RH);
      @(negedge clk);
      nvec++;
      if (boot_done !== 1'b1 || wr_addr.size() != 2 || wr_data[1] !== 32'h00100093) begin
         nerr++;
         $display("FAIL midreset_reboot done=%b writes=%0d want done=1 writes=2", boot_done, wr_addr.size());
      end
      wr_addr.delete();
      wr_data.delete();
      load_basic_frame();
      send_frame(0);
      @(negedge clk);
      nvec++;
      if ({rx_ready, boot_done, cpu_rstn} !== 3'b011 || wr_addr.size() != 0) begin
         nerr++;
         $display("FAIL run_ignore got=%b writes=%0d want=011 writes=0", {rx_ready, boot_done, cpu_rstn}, wr_addr.size());
      end
   endtask

   task automatic test_random();
      int n;
      bit corrupt;
      for (int it = 0; it < 24; it++) begin
         do_reset();
         n = $urandom_range(5, 0);
         corrupt = ($urandom_range(3, 0) == 0);
         build_frame(n, corrupt);
         send_frame(3);
         @(negedge clk);
         nvec++;
         if (wr_addr.size() != exp_addr.size()) begin
            nerr++;
            $display("FAIL rand%0d_wr_count got=%0d want=%0d", it, wr_addr.size(), exp_addr.size());
         end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
               nvec++;
               if (wr_addr[i] != exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                  nerr++;
                  $display("FAIL rand%0d_wr%0d got=(%0d,%h) want=(%0d,%h)",
                           it, i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
               end
            end
         end
         idle(RH + 1);
         @(negedge clk);
         nvec++;
         if ({cpu_rstn, boot_done, boot_err} !== {exp_ok, exp_ok, !exp_ok}) begin
            nerr++;
            $display("FAIL rand%0d_outcome n=%0d got=%b want=%b", it, n,
                     {cpu_rstn, boot_done, boot_err}, {exp_ok, exp_ok, !exp_ok});
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_csum();
      test_zero_len();
      test_oversize();
      test_full_capacity();
      test_timeout();
      test_reset_mid_and_run();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
